pll_freq_monitor: RTL and testbench

Frequency monitor for the PLL output clock, running in the 27 MHz reference clock domain. It samples a divide-by-32 toggle produced in the PLL output domain and counts its edges over a fixed gate window of reference cycles. It checks each count against expected bounds and asserts `freq_ok` once enough consecutive windows pass. Its outputs gate downstream video/HDMI logic and drive the board status LED.

---
 rtl/pll_freq_mon_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 30 +++
 rtl/pll_freq_monitor.sv | 147 ++++++++++++++
 tb/tb_pll_freq_monitor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_freq_mon_pkg.sv
// Shared types and constants for the PLL frequency monitor.
package pll_freq_mon_pkg;

    // Monitor sequencing: idle, discarded priming window, live measurement.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        MEASURE = 2'd2
    } mon_state_t;

    // PLL output cycles per tgl_in flip (each flip is one counted edge).
    localparam int TGL_DIV = 32;

    // Nominal operating point used to derive the expected window count.
    localparam int REF_CLK_KHZ     = 27_000;
    localparam int PLL_CLK_KHZ     = 135_000;
    localparam int PLL_REF_RATIO   = PLL_CLK_KHZ / REF_CLK_KHZ;
    localparam int GATE_CYCLES_DEF = 2700;

    // Whole tgl_in edges expected in a gate window of the given length.
    function automatic int nominal_edges(input int gate_cycles);
        return (gate_cycles * PLL_REF_RATIO) / TGL_DIV;
    endfunction

    localparam int NOM_EDGES = nominal_edges(GATE_CYCLES_DEF);

endpackage

// File: rtl/sync_edge_det.sv
// Brings the PLL-domain toggle into the reference domain and turns every
// transition (rising or falling) into a one-cycle registered pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync_meta;
    logic sync_q;
    logic delay_q;

    // Two-stage synchronizer, delay stage and registered XOR edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            delay_q    <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage capture the previous stage's old value.
            sync_meta  <= async_in;
            sync_q     <= sync_meta;
            delay_q    <= sync_q;
            edge_pulse <= sync_q ^ delay_q;
        end
    end

endmodule

// File: rtl/pll_freq_monitor.sv
// PLL output frequency monitor in the 27 MHz reference domain.
// Counts tgl_in edges over fixed gate windows, checks each count against
// [EXP_MIN, EXP_MAX] and raises freq_ok after GOOD_WINDOWS passing windows.
// Build option: define PLL_FREQ_MON_STICKY_FAULT_EN to make fault sticky
// until clear_fault; otherwise fault follows the last evaluated window.
module pll_freq_monitor
    import pll_freq_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = 2700,
    parameter int EXP_MIN      = 418,
    parameter int EXP_MAX      = 426,
    parameter int GOOD_WINDOWS = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tgl_in,
    input  logic             clear_fault,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             fault
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  CNT_HIGH  = CNT_W'(EXP_MAX);
    localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(GOOD_WINDOWS);

    mon_state_t        state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_sum;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_next;
    logic              edge_pulse;
    logic              terminal;
    logic              window_pass;

    sync_edge_det u_sync_edge_det (
        .clk        (clkin),
        .rst_n      (rst_n),
        .async_in   (tgl_in),
        .edge_pulse (edge_pulse)
    );

    // Window arithmetic: terminal flag, count including this cycle's edge, pass test, next good count.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        terminal    = (state != IDLE) && (gate_cnt == GATE_LAST);
        edge_sum    = edge_cnt;
        good_next   = good_cnt;
        if (edge_pulse && (edge_cnt != CNT_MAX)) begin
            edge_sum = edge_cnt + CNT_W'(1);
        end
        window_pass = (edge_sum >= CNT_MIN) && (edge_sum <= CNT_HIGH);
        if (good_cnt != GOOD_FULL) begin
            good_next = good_cnt + GOOD_W'(1);
        end
    end

    // Gate and edge counters: held at zero while idle, restarted at each terminal count.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if ((state == IDLE) || !enable) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (terminal) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_sum;
        end
    end

`ifndef PLL_FREQ_MON_STICKY_FAULT_EN
    // clear_fault has no effect when fault simply mirrors the last window.
    logic unused_clear_fault;
    assign unused_clear_fault = clear_fault;
`endif

    // Sequencing FSM with registered measurement and status outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            meas_count <= '0;
            meas_valid <= 1'b0;
            good_cnt   <= '0;
            freq_ok    <= 1'b0;
            fault      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
`ifdef PLL_FREQ_MON_STICKY_FAULT_EN
            // A failing window below assigns later and therefore wins over the clear.
            if (clear_fault) begin
                fault <= 1'b0;
            end
`endif
            if (!enable) begin
                state    <= IDLE;
                good_cnt <= '0;
                freq_ok  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= PRIME;
                    end
                    PRIME: begin
                        // The first window after enable may be partial in spirit; it is never reported.
                        if (terminal) begin
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (terminal) begin
                            meas_count <= edge_sum;
                            meas_valid <= 1'b1;
                            if (window_pass) begin
                                good_cnt <= good_next;
                                freq_ok  <= (good_next == GOOD_FULL);
`ifndef PLL_FREQ_MON_STICKY_FAULT_EN
                                fault    <= 1'b0;
`endif
                            end else begin
                                good_cnt <= '0;
                                freq_ok  <= 1'b0;
                                fault    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Self-checking bench for pll_freq_monitor. A window-level reference model
// sums scheduled tgl_in edges over each gate window and applies the pass,
// good-count and fault rules directly.
`timescale 1ns/100ps
module tb_pll_freq_monitor;

    localparam int GATE      = 2700;
    localparam int EXP_MIN   = 418;
    localparam int EXP_MAX   = 426;
    localparam int GOOD      = 4;
    localparam int CNT_W     = 16;
    localparam int TGL_UNITS = 32 * 27000;   // phase units per tgl_in flip

    logic             clkin       = 1'b0;
    logic             rst_n       = 1'b0;
    logic             enable      = 1'b0;
    logic             tgl_in      = 1'b0;
    logic             clear_fault = 1'b0;
    logic [CNT_W-1:0] meas_count;
    logic             meas_valid;
    logic             freq_ok;
    logic             fault;

    pll_freq_monitor #(
        .GATE_CYCLES  (GATE),
        .EXP_MIN      (EXP_MIN),
        .EXP_MAX      (EXP_MAX),
        .GOOD_WINDOWS (GOOD),
        .CNT_W        (CNT_W)
    ) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .enable      (enable),
        .tgl_in      (tgl_in),
        .clear_fault (clear_fault),
        .meas_count  (meas_count),
        .meas_valid  (meas_valid),
        .freq_ok     (freq_ok),
        .fault       (fault)
    );

    always #18.5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus: phase accumulator in units of 1/27000 PLL cycles per ref cycle.
    int pll_khz = 135000;
    bit tgl_run = 1'b0;
    int phase   = 0;
    bit edge_at [0:131071];

    // Reference model state.
    bit               m_active;
    int               m_p0;
    logic [CNT_W-1:0] m_count;
    bit               m_valid;
    bit               m_ok;
    bit               m_fault;
    int               m_good;

    int valid_seen;
    int first_ok_cyc;
    int en_cyc;
    bit chk_nominal;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int window_edges(input int last);
        int n = 0;
        for (int i = last - GATE + 1; i <= last; i++) n += int'(edge_at[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_count  = '0;
        m_valid  = 0;
        m_ok     = 0;
        m_fault  = 0;
        m_good   = 0;
    endtask

    // One model update per clock, using the inputs that were stable at that edge.
    task automatic model_step();
        int n;
        m_valid = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef PLL_FREQ_MON_STICKY_FAULT_EN
        if (clear_fault) m_fault = 0;
`endif
        if (!enable) begin
            m_active = 0;
            m_ok     = 0;
            m_good   = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_p0     = cyc;
        end else if (((cyc - m_p0) % GATE == 0) && ((cyc - m_p0) >= 2 * GATE)) begin
            n = window_edges(cyc);
            if (n > 65535) n = 65535;
            m_count = CNT_W'(n);
            m_valid = 1;
            if (n >= EXP_MIN && n <= EXP_MAX) begin
                m_good = (m_good < GOOD) ? m_good + 1 : GOOD;
                m_ok   = (m_good == GOOD);
`ifndef PLL_FREQ_MON_STICKY_FAULT_EN
                m_fault = 0;
`endif
            end else begin
                m_good  = 0;
                m_ok    = 0;
                m_fault = 1;
            end
        end
    endtask

    // Advance one clock: drive tgl_in at the falling edge, compare after the next falling edge.
    task automatic tick();
        if (tgl_run && rst_n) begin
            phase += pll_khz;
            if (phase >= TGL_UNITS) begin
                phase -= TGL_UNITS;
                tgl_in = ~tgl_in;
                edge_at[cyc + 4] = 1'b1;   // seen three cycles later, counted on the following edge
            end
        end
        @(posedge clkin);
        cyc++;
        @(negedge clkin);
        model_step();
        check("meas_valid", 32'(meas_valid), 32'(m_valid));
        check("meas_count", 32'(meas_count), 32'(m_count));
        check("freq_ok",    32'(freq_ok),    32'(m_ok));
        check("fault",      32'(fault),      32'(m_fault));
        if (meas_valid) begin
            valid_seen++;
            if (chk_nominal) check("nominal_count_421_422", 32'(meas_count == 421 || meas_count == 422), 32'd1);
        end
        if (freq_ok && first_ok_cyc < 0) first_ok_cyc = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic apply_reset();
        #5;
        rst_n = 1'b0;
        #2;
        check("rst_meas_count", 32'(meas_count), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_freq_ok",    32'(freq_ok),    32'd0);
        check("rst_fault",      32'(fault),      32'd0);
        tgl_run     = 1'b0;
        tgl_in      = 1'b0;
        enable      = 1'b0;
        clear_fault = 1'b0;
        for (int i = cyc + 1; i <= cyc + 5; i++) edge_at[i] = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int khz;
        int windows;
        bit exp_ok;
        bit exp_fault;
        bit nominal;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int k;
        first_ok_cyc = -1;
        chk_nominal  = 1'b0;
        model_reset();

        vecs[0] = '{130000, 2, 1'b0, 1'b1, 1'b0};   // slow PLL, ~406 edges
        vecs[1] = '{133900, 2, 1'b0, 1'b0, 1'b0};   // ~418.4 edges, lower bound passes
        vecs[2] = '{136300, 2, 1'b0, 1'b0, 1'b0};   // ~425.9 edges, upper bound passes
        vecs[3] = '{135000, 5, 1'b1, 1'b0, 1'b1};   // nominal, reaches freq_ok

        @(negedge clkin);

        // Table-driven runs from reset with a fixed PLL rate each.
        for (int v = 0; v < 4; v++) begin
            apply_reset();
            pll_khz      = vecs[v].khz;
            phase        = int'($urandom_range(0, TGL_UNITS - 1));
            tgl_run      = 1'b1;
            chk_nominal  = vecs[v].nominal;
            valid_seen   = 0;
            first_ok_cyc = -1;
            enable       = 1'b1;
            en_cyc       = cyc;
            run(vecs[v].windows * GATE + 1);
            check($sformatf("vec%0d_freq_ok", v), 32'(freq_ok), 32'(vecs[v].exp_ok));
            check($sformatf("vec%0d_fault", v),   32'(fault),   32'(vecs[v].exp_fault));
            check($sformatf("vec%0d_valid_pulses", v), 32'(valid_seen), 32'(vecs[v].windows - 1));
            if (vecs[v].exp_ok) check("freq_ok_latency", 32'(first_ok_cyc - en_cyc), 32'd13501);
        end

        // Enable dropped mid-window while freq_ok is high, then a fresh PRIME window.
        run(1000);
        enable = 1'b0;
        tick();
        check("drop_freq_ok_next_cycle", 32'(freq_ok), 32'd0);
        valid_seen = 0;
        run(50);
        enable = 1'b1;
        run(GATE + 1);
        check("reenable_prime_discarded", 32'(valid_seen), 32'd0);
        run(GATE);
        check("reenable_first_valid", 32'(valid_seen), 32'd1);
        run(3 * GATE);
        check("reenable_freq_ok", 32'(freq_ok), 32'd1);

        // Lost clock: tgl_in frozen partway through a window.
        chk_nominal = 1'b0;
        run(1000);
        tgl_run = 1'b0;
        run(GATE - 1000);
        check("lost_partial_freq_ok", 32'(freq_ok), 32'd0);
        check("lost_partial_fault",   32'(fault),   32'd1);
        run(GATE);
        check("lost_count_zero", 32'(meas_count), 32'd0);
        check("lost_fault",      32'(fault),      32'd1);

        // Randomized rates: good prime, bad window with clear on its terminal cycle, then good windows.
        apply_reset();
        phase   = int'($urandom_range(0, TGL_UNITS - 1));
        pll_khz = int'($urandom_range(134000, 136000));
        tgl_run = 1'b1;
        enable  = 1'b1;
        run(GATE + 1);
        pll_khz = ($urandom_range(0, 1) == 0) ? int'($urandom_range(124000, 132000))
                                              : int'($urandom_range(139000, 144000));
        run(GATE - 1);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("fault_set_wins_over_clear", 32'(fault), 32'd1);
        pll_khz = int'($urandom_range(134000, 136000));
        run(GATE);
`ifdef PLL_FREQ_MON_STICKY_FAULT_EN
        check("sticky_fault_after_good", 32'(fault), 32'd1);
`else
        check("fault_clears_after_good", 32'(fault), 32'd0);
`endif
        pll_khz = int'($urandom_range(134000, 136000));
        k = int'($urandom_range(10, 2000));
        run(k);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("fault_after_clear_pulse", 32'(fault), 32'd0);
        run(GATE - k - 1);
        check("random_fault_final",   32'(fault),   32'd0);
        check("random_freq_ok_final", 32'(freq_ok), 32'd0);

        // Reset in the middle of a MEASURE window.
        run(1500);
        check("pre_reset_count_nonzero", 32'(meas_count != 0), 32'd1);
        apply_reset();
        pll_khz     = 135000;
        tgl_run     = 1'b1;
        valid_seen  = 0;
        enable      = 1'b1;
        run(GATE + 1);
        check("post_reset_prime_no_valid", 32'(valid_seen), 32'd0);
        chk_nominal = 1'b1;
        run(GATE);
        check("post_reset_first_valid", 32'(valid_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
